instr_encoder_loader: RTL

Inverse of the instruction field decoder. Accepts decoded RISC-V field tuples over a valid/ready handshake and packs each one into a 32-bit RV32I instruction word by format (R/I/S/B/U/J). Writes the words sequentially into instruction memory through a single-cycle write port. Used as the program/self-test loader that fills instruction memory ahead of the datapath.

---
 rtl/rv_isa_pkg.sv | 26 ++
 rtl/instr_field_packer.sv | 32 +++
 rtl/instr_encoder_loader.sv | 101 ++++++++++
 3 files changed

// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoding constants and the loader state type.
package rv_isa_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_e;

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: decoded RV32I fields plus format code -> instruction word.
module instr_field_packer
  import rv_isa_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  func3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [6:0]  func7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  // B and J immediates arrive as byte offsets, so bit 0 is dropped by the scramble.
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (fmt)
      FMT_R:   word = {func7, rs2, rs1, func3, rd, opcode};
      FMT_I:   word = {imm[11:0], rs1, func3, rd, opcode};
      FMT_S:   word = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
      FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
      FMT_U:   word = {imm[31:12], rd, opcode};
      FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Loads packed RV32I words into instruction memory, one per accepted field tuple.
module instr_encoder_loader
  import rv_isa_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 64,
  parameter int BASE_ADDR = 0,
  localparam int CW       = $clog2(MAX_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [2:0]        func3,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [6:0]        func7,
  input  logic [31:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [CW-1:0]     word_count,
  output logic              busy,
  output logic              done,
  output logic              fmt_err
);

  if ((BASE_ADDR % 4 != 0) ||
      (longint'(BASE_ADDR) + 4 * longint'(MAX_WORDS) > (longint'(1) << ADDR_W))) begin : g_param_chk
    $error("instr_encoder_loader: BASE_ADDR must be word aligned and the image must fit ADDR_W");
  end

  load_state_e state;
  logic [31:0] word;
  logic        illegal;
  logic        accept;

  instr_field_packer u_packer (
    .fmt    (fmt),
    .opcode (opcode),
    .rd     (rd),
    .func3  (func3),
    .rs1    (rs1),
    .rs2    (rs2),
    .func7  (func7),
    .imm    (imm),
    .word   (word),
    .illegal(illegal)
  );

  // word_count advances at accept, so it already counts the in-flight write.
  assign in_ready = (state == ST_LOAD) && (word_count < CW'(MAX_WORDS)) && !finish;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_count <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      fmt_err    <= 1'b0;
    end else begin
      mem_we  <= 1'b0;
      fmt_err <= 1'b0;
      if (accept) begin
        if (illegal) begin
          fmt_err <= 1'b1;
        end else begin
          mem_we     <= 1'b1;
          mem_addr   <= ADDR_W'(BASE_ADDR + 4 * int'(word_count));
          mem_wdata  <= word;
          word_count <= word_count + CW'(1);
        end
      end
      // Leaving LOAD lines up with the write cycle ending, so DONE never overlaps mem_we.
      case (state)
        ST_LOAD: if (finish || (mem_we && word_count == CW'(MAX_WORDS))) begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: ;
      endcase
      if (start) begin
        state      <= ST_LOAD;
        busy       <= 1'b1;
        done       <= 1'b0;
        word_count <= '0;
      end
    end
  end

endmodule
